// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: owns the PC, arbitrates redirects, issues one icache request at a time
// and hands fetched instructions to decode, discarding responses made stale by a redirect.
module fetch_seq_ctrl #(
    parameter int unsigned       ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h8000_0000,
    parameter int unsigned       CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clint_pc_valid_i,
    input  logic [ADDR_W-1:0] clint_pc_i,
    input  logic              branch_pc_valid_i,
    input  logic [ADDR_W-1:0] branch_pc_i,
    input  logic              bpu_pc_valid_i,
    input  logic [ADDR_W-1:0] bpu_pc_i,
    output logic              icache_req_valid_o,
    input  logic              icache_req_ready_i,
    output logic [ADDR_W-1:0] icache_req_addr_o,
    input  logic              icache_resp_valid_i,
    input  logic [31:0]       icache_resp_data_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic [ADDR_W-1:0] fetch_pc_o,
    output logic [CNT_W-1:0]  drop_cnt_o
);

    typedef enum logic [1:0] {StReq, StWait, StDrop, StHold} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] redir_pc_q, redir_pc_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic              redir_pending_q, redir_pending_d;
    logic              lock_q, lock_d;
    logic              stale_q, stale_d;
    logic              hold_valid_q, hold_valid_d;

    logic              any_redir;
    logic [ADDR_W-1:0] redir_tgt;
    logic [ADDR_W-1:0] issue_addr;
    logic              req_hs;
    logic              inst_hs;
    logic              drop_resp;

    // Fixed priority: trap beats branch beats prediction.
    always_comb begin
        any_redir = clint_pc_valid_i | branch_pc_valid_i | bpu_pc_valid_i;
        redir_tgt = bpu_pc_i;
        if (branch_pc_valid_i) redir_tgt = branch_pc_i;
        if (clint_pc_valid_i)  redir_tgt = clint_pc_i;
    end

    // Once a request has been presented without being accepted, its address is frozen.
    assign issue_addr = lock_q ? req_addr_q : (redir_pending_q ? redir_pc_q : fetch_pc_q);

    assign icache_req_valid_o = (state_q == StReq) && !rst;
    assign icache_req_addr_o  = issue_addr;
    assign req_hs             = icache_req_valid_o && icache_req_ready_i;

    // A redirect in the same cycle kills the held instruction, which is younger.
    assign inst_valid_o = hold_valid_q && !any_redir;
    assign inst_hs      = inst_valid_o && inst_ready_i;
    assign inst_o       = inst_q;
    assign inst_pc_o    = inst_pc_q;
    assign fetch_pc_o   = fetch_pc_q;
    assign drop_cnt_o   = drop_cnt_q;

    always_comb begin
        state_d         = state_q;
        fetch_pc_d      = fetch_pc_q;
        redir_pc_d      = redir_pc_q;
        redir_pending_d = redir_pending_q;
        req_addr_d      = req_addr_q;
        lock_d          = lock_q;
        stale_d         = stale_q;
        hold_valid_d    = hold_valid_q;
        inst_d          = inst_q;
        inst_pc_d       = inst_pc_q;
        drop_resp       = 1'b0;

        if (any_redir) begin
            redir_pc_d      = redir_tgt;
            redir_pending_d = 1'b1;
        end

        unique case (state_q)
            StReq: begin
                if (req_hs) begin
                    fetch_pc_d = issue_addr;
                    lock_d     = 1'b0;
                    stale_d    = 1'b0;
                    if (stale_q || any_redir) begin
                        state_d = StDrop;
                    end else begin
                        redir_pending_d = 1'b0;
                        state_d         = StWait;
                    end
                end else if (icache_req_valid_o) begin
                    if (!lock_q) begin
                        lock_d     = 1'b1;
                        req_addr_d = issue_addr;
                    end
                    if (any_redir) stale_d = 1'b1;
                end
            end
            StWait: begin
                if (icache_resp_valid_i) begin
                    if (redir_pending_q || any_redir) begin
                        drop_resp = 1'b1;
                        state_d   = StReq;
                    end else begin
                        hold_valid_d = 1'b1;
                        inst_d       = icache_resp_data_i;
                        inst_pc_d    = fetch_pc_q;
                        state_d      = StHold;
                    end
                end else if (any_redir) begin
                    state_d = StDrop;
                end
            end
            StDrop: begin
                if (icache_resp_valid_i) begin
                    drop_resp = 1'b1;
                    state_d   = StReq;
                end
            end
            StHold: begin
                if (inst_hs) begin
                    fetch_pc_d   = inst_pc_q + ((inst_q[1:0] != 2'b11) ? ADDR_W'(2) : ADDR_W'(4));
                    hold_valid_d = 1'b0;
                    state_d      = StReq;
                end else if (any_redir) begin
                    hold_valid_d = 1'b0;
                    state_d      = StReq;
                end
            end
            default: state_d = StReq;
        endcase
    end

    assign drop_cnt_d = (drop_resp && (drop_cnt_q != {CNT_W{1'b1}})) ? drop_cnt_q + 1'b1
                                                                     : drop_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StReq;
            fetch_pc_q      <= RESET_ADDR;
            redir_pc_q      <= '0;
            redir_pending_q <= 1'b0;
            req_addr_q      <= '0;
            lock_q          <= 1'b0;
            stale_q         <= 1'b0;
            hold_valid_q    <= 1'b0;
            inst_q          <= '0;
            inst_pc_q       <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            fetch_pc_q      <= fetch_pc_d;
            redir_pc_q      <= redir_pc_d;
            redir_pending_q <= redir_pending_d;
            req_addr_q      <= req_addr_d;
            lock_q          <= lock_d;
            stale_q         <= stale_d;
            hold_valid_q    <= hold_valid_d;
            inst_q          <= inst_d;
            inst_pc_q       <= inst_pc_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed bench for fetch_seq_ctrl: inputs change and outputs are sampled on the falling edge.
module tb_fetch_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        clint_pc_valid_i, branch_pc_valid_i, bpu_pc_valid_i;
    logic [31:0] clint_pc_i, branch_pc_i, bpu_pc_i;
    logic        icache_req_valid_o, icache_req_ready_i;
    logic [31:0] icache_req_addr_o;
    logic        icache_resp_valid_i;
    logic [31:0] icache_resp_data_i;
    logic        inst_valid_o, inst_ready_i;
    logic [31:0] inst_o, inst_pc_o, fetch_pc_o;
    logic [7:0]  drop_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_seq_ctrl dut (
        .clk                 (clk),
        .rst                 (rst),
        .clint_pc_valid_i    (clint_pc_valid_i),
        .clint_pc_i          (clint_pc_i),
        .branch_pc_valid_i   (branch_pc_valid_i),
        .branch_pc_i         (branch_pc_i),
        .bpu_pc_valid_i      (bpu_pc_valid_i),
        .bpu_pc_i            (bpu_pc_i),
        .icache_req_valid_o  (icache_req_valid_o),
        .icache_req_ready_i  (icache_req_ready_i),
        .icache_req_addr_o   (icache_req_addr_o),
        .icache_resp_valid_i (icache_resp_valid_i),
        .icache_resp_data_i  (icache_resp_data_i),
        .inst_valid_o        (inst_valid_o),
        .inst_ready_i        (inst_ready_i),
        .inst_o              (inst_o),
        .inst_pc_o           (inst_pc_o),
        .fetch_pc_o          (fetch_pc_o),
        .drop_cnt_o          (drop_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst                 = 1'b1;
        clint_pc_valid_i    = 1'b0;
        branch_pc_valid_i   = 1'b0;
        bpu_pc_valid_i      = 1'b0;
        clint_pc_i          = '0;
        branch_pc_i         = '0;
        bpu_pc_i            = '0;
        icache_req_ready_i  = 1'b1;
        icache_resp_valid_i = 1'b0;
        icache_resp_data_i  = '0;
        inst_ready_i        = 1'b1;

        // Reset values
        step(); step();
        check_eq("rst_req_valid", 32'(icache_req_valid_o), 32'd0);
        check_eq("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("rst_inst", inst_o, 32'd0);
        check_eq("rst_inst_pc", inst_pc_o, 32'd0);
        check_eq("rst_fetch_pc", fetch_pc_o, 32'h8000_0000);
        check_eq("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);

        // Plain fetch of a 32-bit instruction
        rst = 1'b0; #1;
        check_eq("f0_req_valid", 32'(icache_req_valid_o), 32'd1);
        check_eq("f0_req_addr", icache_req_addr_o, 32'h8000_0000);
        step(); icache_req_ready_i = 1'b0; #1;
        check_eq("f0_wait_req_valid", 32'(icache_req_valid_o), 32'd0);
        step(); icache_resp_valid_i = 1'b1; icache_resp_data_i = 32'h0000_0013; #1;
        check_eq("f0_no_early_inst", 32'(inst_valid_o), 32'd0);
        step(); icache_resp_valid_i = 1'b0; #1;
        check_eq("f0_inst_valid", 32'(inst_valid_o), 32'd1);
        check_eq("f0_inst", inst_o, 32'h0000_0013);
        check_eq("f0_inst_pc", inst_pc_o, 32'h8000_0000);
        step(); icache_req_ready_i = 1'b1; #1;
        check_eq("f1_req_addr", icache_req_addr_o, 32'h8000_0004);
        check_eq("f1_fetch_pc", fetch_pc_o, 32'h8000_0004);

        // Compressed instruction advances by 2
        step(); icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1;
        icache_resp_data_i = 32'h0000_4501;
        step(); icache_resp_valid_i = 1'b0; #1;
        check_eq("c_inst_valid", 32'(inst_valid_o), 32'd1);
        check_eq("c_inst_pc", inst_pc_o, 32'h8000_0004);
        step(); icache_req_ready_i = 1'b1; #1;
        check_eq("c_req_addr", icache_req_addr_o, 32'h8000_0006);

        // Branch in WAIT before the response: response discarded
        step(); icache_req_ready_i = 1'b0; inst_ready_i = 1'b0;
        branch_pc_valid_i = 1'b1; branch_pc_i = 32'h8000_0100;
        step(); branch_pc_valid_i = 1'b0; icache_resp_valid_i = 1'b1;
        icache_resp_data_i = 32'hdead_beef; #1;
        check_eq("br_drop_req_valid", 32'(icache_req_valid_o), 32'd0);
        step(); icache_resp_valid_i = 1'b0; icache_req_ready_i = 1'b1; #1;
        check_eq("br_no_stale_inst", 32'(inst_valid_o), 32'd0);
        check_eq("br_drop_cnt", 32'(drop_cnt_o), 32'd1);
        check_eq("br_req_addr", icache_req_addr_o, 32'h8000_0100);

        // Three simultaneous redirects during WAIT: trap wins
        step(); icache_req_ready_i = 1'b0;
        clint_pc_valid_i = 1'b1; clint_pc_i = 32'h8000_0200;
        branch_pc_valid_i = 1'b1; branch_pc_i = 32'h8000_0100;
        bpu_pc_valid_i = 1'b1; bpu_pc_i = 32'h8000_0300;
        step(); clint_pc_valid_i = 1'b0; branch_pc_valid_i = 1'b0; bpu_pc_valid_i = 1'b0;
        icache_resp_valid_i = 1'b1;
        step(); icache_resp_valid_i = 1'b0; icache_req_ready_i = 1'b1; #1;
        check_eq("prio_req_addr", icache_req_addr_o, 32'h8000_0200);
        check_eq("prio_drop_cnt", 32'(drop_cnt_o), 32'd2);

        // HOLD stall, then branch kills the held instruction
        step(); icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1;
        icache_resp_data_i = 32'h0000_0013;
        step(); icache_resp_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check_eq("stall_inst_valid", 32'(inst_valid_o), 32'd1);
            step();
        end
        branch_pc_valid_i = 1'b1; branch_pc_i = 32'h8000_0400; inst_ready_i = 1'b1; #1;
        check_eq("kill_inst_valid", 32'(inst_valid_o), 32'd0);
        step(); branch_pc_valid_i = 1'b0; inst_ready_i = 1'b0; #1;
        check_eq("kill_req_addr", icache_req_addr_o, 32'h8000_0400);
        check_eq("kill_fetch_pc", fetch_pc_o, 32'h8000_0200);
        check_eq("kill_inst_gone", 32'(inst_valid_o), 32'd0);

        // Unaccepted request keeps its address across a predicted redirect
        for (int i = 0; i < 4; i++) begin
            bpu_pc_valid_i = (i == 1); bpu_pc_i = 32'h8000_0040; #1;
            check_eq("stall_req_addr", icache_req_addr_o, 32'h8000_0400);
            step();
        end
        bpu_pc_valid_i = 1'b0; icache_req_ready_i = 1'b1; #1;
        check_eq("stall_acc_addr", icache_req_addr_o, 32'h8000_0400);
        step(); icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1; #1;
        check_eq("stale_req_valid", 32'(icache_req_valid_o), 32'd0);
        check_eq("stale_fetch_pc", fetch_pc_o, 32'h8000_0400);
        step(); icache_resp_valid_i = 1'b0; icache_req_ready_i = 1'b1; #1;
        check_eq("bpu_req_addr", icache_req_addr_o, 32'h8000_0040);
        check_eq("bpu_drop_cnt", 32'(drop_cnt_o), 32'd3);
        check_eq("bpu_no_inst", 32'(inst_valid_o), 32'd0);

        // Reset in WAIT takes effect immediately; late response ignored
        step(); icache_req_ready_i = 1'b0; rst = 1'b1; #1;
        check_eq("mid_rst_req_valid", 32'(icache_req_valid_o), 32'd0);
        check_eq("mid_rst_fetch_pc", fetch_pc_o, 32'h8000_0000);
        check_eq("mid_rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
        check_eq("mid_rst_inst", inst_o, 32'd0);
        check_eq("mid_rst_inst_pc", inst_pc_o, 32'd0);
        step(); rst = 1'b0; icache_resp_valid_i = 1'b1; #1;
        check_eq("post_rst_req_addr", icache_req_addr_o, 32'h8000_0000);
        step(); icache_resp_valid_i = 1'b0; #1;
        check_eq("post_rst_inst_valid", 32'(inst_valid_o), 32'd0);
        check_eq("post_rst_req_valid", 32'(icache_req_valid_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
